// File: rtl/updown_pkg.sv
// Shared definitions for the up/down guessing game: hint patterns, widths,
// player FSM encoding and the decoded-hint bundle.
package updown_pkg;

  localparam int NUM_W = 7;
  localparam int SEG_W = 7;

  // Hint patterns shown by the game block; both ends must agree on these.
  localparam logic [SEG_W-1:0] SEG_UP   = 7'b0111110;
  localparam logic [SEG_W-1:0] SEG_DOWN = 7'b1011110;
  localparam logic [SEG_W-1:0] SEG_OK   = 7'b0111111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GUESS,
    ST_WAIT,
    ST_EVAL,
    ST_DONE,
    ST_FAIL
  } state_e;

  typedef struct packed {
    logic is_up;
    logic is_down;
    logic is_ok;
    logic is_unknown;
  } hint_t;

  // Midpoint of the search window using an 8-bit sum; low can reach 128
  // and high is at most 127, so the sum never wraps.
  function automatic logic [7:0] mid_of(input logic [7:0] lo, input logic [7:0] hi);
    logic [7:0] sum;
    sum = lo + hi;
    return {1'b0, sum[7:1]};
  endfunction

endpackage

// File: rtl/updown_auto_player_if.sv
// Guess interface between the automatic player (master) and the game /
// observer side (slave).
interface updown_auto_player_if;
  import updown_pkg::*;

  logic             start;
  logic [SEG_W-1:0] seg_display;
  logic             game_over;
  logic [NUM_W-1:0] user_number;
  logic             guess_trigger;
  logic             busy;
  logic             done;
  logic             fail;
  logic [3:0]       guess_count;
  logic [NUM_W-1:0] found_number;

  modport master (
    input  start, seg_display, game_over,
    output user_number, guess_trigger, busy, done, fail, guess_count, found_number
  );

  modport slave (
    output start, seg_display, game_over,
    input  user_number, guess_trigger, busy, done, fail, guess_count, found_number
  );

endinterface

// File: rtl/updown_hint_decode.sv
// Combinational classifier of the game's seg_display hint.
module updown_hint_decode
  import updown_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output hint_t            hint_o
);

  // Exactly one of the four flags is high for any pattern.
  always_comb begin
    hint_o.is_up      = (seg_i == SEG_UP);
    hint_o.is_down    = (seg_i == SEG_DOWN);
    hint_o.is_ok      = (seg_i == SEG_OK);
    hint_o.is_unknown = !(hint_o.is_up || hint_o.is_down || hint_o.is_ok);
  end

endmodule

// File: rtl/updown_auto_player.sv
// Binary-search guesser for the up/down game. Issues one guess per
// GUESS/WAIT/EVAL round, narrows [low, high] from the hint and stops in
// DONE (found) or FAIL (contradiction, budget, game_over or timeout).
module updown_auto_player
  import updown_pkg::*;
#(
  parameter int LO_INIT     = 0,
  parameter int HI_INIT     = 127,
  parameter int RESP_WAIT   = 4,   // must be >= 1
  parameter int TIMEOUT     = 16,  // must be >= 1
  parameter int MAX_GUESSES = 10
) (
  input logic clk,
  input logic reset,
  updown_auto_player_if.master gif
);

  localparam int WCNT_W = $clog2(RESP_WAIT + TIMEOUT + 1);
  localparam logic [7:0]        LO8       = 8'(LO_INIT);
  localparam logic [7:0]        HI8       = 8'(HI_INIT);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(RESP_WAIT - 1);
  localparam logic [WCNT_W-1:0] EVAL_LAST = WCNT_W'(RESP_WAIT + TIMEOUT - 1);
  localparam logic [3:0]        MAX_CNT   = 4'(MAX_GUESSES);

  state_e            state_q, state_d;
  logic [7:0]        low_q, low_d;
  logic [7:0]        high_q, high_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [NUM_W-1:0]  num_q, num_d;
  logic              trig_q, trig_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [NUM_W-1:0]  found_q, found_d;

  logic [7:0] mid, mid_p1, mid_m1;
  logic       bad;
  hint_t      dec;

  updown_hint_decode u_dec (
    .seg_i  (gif.seg_display),
    .hint_o (dec)
  );

  // low/high are untouched between GUESS and EVAL, so mid here always
  // equals the guess currently on user_number.
  always_comb begin
    mid    = mid_of(low_q, high_q);
    mid_p1 = mid + 8'd1;
    mid_m1 = mid - 8'd1;
  end

  // Next-state and register-update logic for the search FSM.
  always_comb begin
    state_d = state_q;
    low_d   = low_q;
    high_d  = high_q;
    wcnt_d  = wcnt_q;
    num_d   = num_q;
    trig_d  = 1'b0;
    cnt_d   = cnt_q;
    done_d  = done_q;
    fail_d  = fail_q;
    found_d = found_q;
    bad     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (gif.start) begin
          low_d   = LO8;
          high_d  = HI8;
          cnt_d   = '0;
          done_d  = 1'b0;
          fail_d  = 1'b0;
          found_d = '0;
          state_d = ST_GUESS;
        end
      end

      ST_GUESS: begin
        num_d   = NUM_W'(mid);
        trig_d  = 1'b1;
        cnt_d   = cnt_q + 4'd1;
        wcnt_d  = '0;
        state_d = ST_WAIT;
      end

      // One counter spans WAIT and EVAL so the timeout is measured from
      // the trigger pulse.
      ST_WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == WAIT_LAST) state_d = ST_EVAL;
      end

      ST_EVAL: begin
        if (dec.is_ok) begin
          found_d = num_q;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (gif.game_over) begin
          fail_d  = 1'b1;
          state_d = ST_FAIL;
        end else if (!dec.is_unknown) begin
          if (dec.is_up) begin
            low_d = mid_p1;
            bad   = (mid_p1 > high_q);
          end else if (dec.is_down) begin
            high_d = mid_m1;
            bad    = (mid == 8'd0) || (low_q > mid_m1);
          end
          if (bad || cnt_q == MAX_CNT) begin
            fail_d  = 1'b1;
            state_d = ST_FAIL;
          end else begin
            state_d = ST_GUESS;
          end
        end else if (wcnt_q == EVAL_LAST) begin
          fail_d  = 1'b1;
          state_d = ST_FAIL;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      low_q   <= LO8;
      high_q  <= HI8;
      wcnt_q  <= '0;
      num_q   <= '0;
      trig_q  <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      found_q <= '0;
    end else begin
      state_q <= state_d;
      low_q   <= low_d;
      high_q  <= high_d;
      wcnt_q  <= wcnt_d;
      num_q   <= num_d;
      trig_q  <= trig_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      found_q <= found_d;
    end
  end

  assign gif.user_number   = num_q;
  assign gif.guess_trigger = trig_q;
  assign gif.busy          = (state_q == ST_GUESS) || (state_q == ST_WAIT) ||
                             (state_q == ST_EVAL);
  assign gif.done          = done_q;
  assign gif.fail          = fail_q;
  assign gif.guess_count   = cnt_q;
  assign gif.found_number  = found_q;

endmodule

// File: tb/tb_updown_auto_player.sv
// Closed-loop bench: a behavioural game answers each guess, a reference
// binary search predicts the guess sequence and outcome, and a monitor
// compares every trigger and every terminal result against those queues.
module tb_updown_auto_player;
  import updown_pkg::*;

  localparam int RW   = 4;
  localparam int TO   = 16;
  localparam int MAXG = 10;

  localparam int M_NORM   = 0;  // honest game
  localparam int M_SILENT = 1;  // never shows a recognisable hint
  localparam int M_GO     = 2;  // game_over without OK on guess goat
  localparam int M_OKGO   = 3;  // game_over raised together with OK

  typedef struct {
    int done;
    int fail;
    int cnt;
    int found;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  int tests = 0;
  int fails = 0;

  int target = 0;
  int mode   = M_NORM;
  int goat   = 0;

  int exp_q[$];
  res_t res_q[$];

  int trig_seen = 0;
  int last_trig = 0;
  int term_cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  updown_auto_player_if gif();

  updown_auto_player #(
    .LO_INIT(0), .HI_INIT(127), .RESP_WAIT(RW), .TIMEOUT(TO), .MAX_GUESSES(MAXG)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .gif   (gif)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain binary search over [0,127] following the game rules.
  task automatic push_expect(input int t, input int m, input int ga);
    int lo, hi, n, mid;
    res_t r;
    lo = 0; hi = 127; n = 0;
    r.done = 0; r.fail = 0; r.cnt = 0; r.found = 0;
    forever begin
      mid = (lo + hi) / 2;
      n++;
      exp_q.push_back(mid);
      if (m == M_SILENT || (m == M_GO && n == ga)) begin r.fail = 1; break; end
      if (mid == t) begin r.done = 1; r.found = mid; break; end
      if (mid < t) lo = mid + 1; else hi = mid - 1;
      if (lo > hi || n == MAXG) begin r.fail = 1; break; end
    end
    r.cnt = n;
    res_q.push_back(r);
  endtask

  // Behavioural game: blanks the display on each trigger, then shows the
  // hint after a random delay that stays inside the player's timeout.
  initial begin : game_model
    int dly;
    int gnum;
    logic [NUM_W-1:0] g;
    dly = 0; gnum = 0; g = '0;
    gif.seg_display = '0;
    gif.game_over   = 1'b0;
    forever begin
      @(negedge clk);
      if (gif.guess_trigger) begin
        g = gif.user_number;
        gnum = int'(gif.guess_count);
        gif.seg_display = '0;
        gif.game_over = 1'b0;
        dly = (mode == M_SILENT) ? 0 : int'($urandom_range(1, RW + 3));
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          if (mode == M_GO && gnum == goat) gif.game_over = 1'b1;
          else if (int'(g) == target) begin
            gif.seg_display = SEG_OK;
            gif.game_over = (mode == M_OKGO);
          end else if (int'(g) < target) gif.seg_display = SEG_UP;
          else gif.seg_display = SEG_DOWN;
        end
      end
    end
  end

  // Monitor: pops one expected guess per trigger, one result per terminal edge.
  initial begin : monitor
    bit prev_term;
    bit term;
    int g;
    res_t r;
    prev_term = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_term = 1'b0;
      end else begin
        if (gif.guess_trigger) begin
          trig_seen++;
          last_trig = cyc;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL extra_trigger: got guess %0d, expected no trigger", gif.user_number);
          end else begin
            g = exp_q.pop_front();
            chk("guess", int'(gif.user_number), g);
          end
        end
        term = gif.done || gif.fail;
        if (term && !prev_term) begin
          term_cyc = cyc;
          if (res_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_end: got done=%0d fail=%0d, expected still running",
                     gif.done, gif.fail);
          end else begin
            r = res_q.pop_front();
            chk("done", int'(gif.done), r.done);
            chk("fail", int'(gif.fail), r.fail);
            chk("guess_count", int'(gif.guess_count), r.cnt);
            if (r.done != 0) chk("found_number", int'(gif.found_number), r.found);
            chk("guesses_left_over", exp_q.size(), 0);
          end
        end
        prev_term = term;
      end
    end
  end

  task automatic pulse_start();
    gif.start = 1'b1;
    @(negedge clk);
    gif.start = 1'b0;
  endtask

  task automatic run(input int t, input int m, input int ga, input bit poke_busy);
    int n;
    target = t; mode = m; goat = ga;
    push_expect(t, m, ga);
    pulse_start();
    chk("start_done_clear", int'(gif.done), 0);
    chk("start_fail_clear", int'(gif.fail), 0);
    chk("start_count_clear", int'(gif.guess_count), 0);
    chk("start_busy", int'(gif.busy), 1);
    n = 0;
    while (!(gif.done || gif.fail) && n < 2000) begin
      @(negedge clk);
      n++;
      if (poke_busy && n == 8) begin
        pulse_start();
        n++;
      end
    end
    if (n >= 2000) begin
      tests++; fails++;
      $display("FAIL search_timeout: target %0d not finished after %0d cycles", t, n);
      exp_q.delete();
      res_q.delete();
    end
    repeat (30) @(negedge clk);
  endtask

  initial begin : main
    int n;
    int base;
    reset = 1'b1;
    gif.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(gif.busy), 0);
    chk("rst_done", int'(gif.done), 0);
    chk("rst_fail", int'(gif.fail), 0);
    chk("rst_count", int'(gif.guess_count), 0);
    chk("rst_user_number", int'(gif.user_number), 0);
    chk("rst_trigger", int'(gif.guess_trigger), 0);
    chk("rst_found", int'(gif.found_number), 0);
    reset = 1'b0;
    @(negedge clk);

    run(85, M_NORM, 0, 1'b0);
    run(0, M_NORM, 0, 1'b0);
    run(127, M_NORM, 0, 1'b0);
    run(128, M_NORM, 0, 1'b0);   // every hint is UP
    run(0, M_SILENT, 0, 1'b0);
    chk("timeout_latency", term_cyc - last_trig, RW + TO);
    run(85, M_GO, 3, 1'b0);
    run(85, M_OKGO, 0, 1'b0);    // OK wins over game_over
    run(42, M_NORM, 0, 1'b1);    // start while busy is ignored

    // Reset during WAIT of the third guess.
    target = 85; mode = M_NORM;
    push_expect(85, M_NORM, 0);
    base = trig_seen;
    pulse_start();
    n = 0;
    while (trig_seen < base + 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("third_trigger_seen", trig_seen - base, 3);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", int'(gif.busy), 0);
    chk("midrst_count", int'(gif.guess_count), 0);
    chk("midrst_user_number", int'(gif.user_number), 0);
    chk("midrst_trigger", int'(gif.guess_trigger), 0);
    reset = 1'b0;
    exp_q.delete();
    res_q.delete();
    @(negedge clk);
    chk("midrst_no_trigger", int'(gif.guess_trigger), 0);
    repeat (5) @(negedge clk);
    run(85, M_NORM, 0, 1'b0);

    repeat (20) run(int'($urandom_range(0, 127)), M_NORM, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
